// File: rtl/fp_div_iter.sv
`default_nettype none
// ============================================================================
// Module      : fp_div_iter
// Description : Iterative IEEE-754 single-precision divider (c = a / b).
//               Restoring mantissa division, one quotient bit per clock,
//               truncated result, denormal inputs flushed to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_div_iter #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int BIAS  = 127
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [EXP_W+MAN_W+1:1] a,
    input  logic [EXP_W+MAN_W+1:1] b,
    output logic                   busy,
    output logic                   done,
    output logic [EXP_W+MAN_W+1:1] c,
    output logic                   nv,
    output logic                   dz,
    output logic                   ovf,
    output logic                   unf
);
    localparam int W     = EXP_W + MAN_W + 1;
    localparam int QBITS = MAN_W + 2;
    localparam int REM_W = MAN_W + 3;
    localparam int CNT_W = $clog2(QBITS);
    localparam int EW2   = EXP_W + 2;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CHECK  = 3'd1;
    localparam logic [2:0] S_DIVIDE = 3'd2;
    localparam logic [2:0] S_NORM   = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam logic [EXP_W-1:0]      C_EXP_ONES = '1;
    localparam logic signed [EW2-1:0] C_BIAS     = EW2'(BIAS);
    localparam logic signed [EW2-1:0] C_EMAX     = EW2'((1 << EXP_W) - 1);
    localparam logic signed [EW2-1:0] C_ONE      = EW2'(1);
    localparam logic signed [EW2-1:0] C_ZERO     = '0;
    localparam logic [W-1:0]          C_QNAN     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    logic [2:0]       r_state,  w_state_d;
    logic [W-1:0]     r_a,      w_a_d;
    logic [W-1:0]     r_b,      w_b_d;
    logic [REM_W-1:0] r_rem,    w_rem_d;
    logic [QBITS-1:0] r_q,      w_q_d;
    logic [CNT_W-1:0] r_cnt,    w_cnt_d;
    logic             r_spec,   w_spec_d;
    logic [W-1:0]     r_spec_c, w_spec_c_d;
    logic             r_spec_nv, w_spec_nv_d;
    logic             r_spec_dz, w_spec_dz_d;
    logic [W-1:0]     r_c,      w_c_d;
    logic             r_nv,     w_nv_d;
    logic             r_dz,     w_dz_d;
    logic             r_ovf,    w_ovf_d;
    logic             r_unf,    w_unf_d;

    // Operand unpack from the captured words
    logic             w_sa, w_sb, w_sign;
    logic [EXP_W-1:0] w_ea, w_eb;
    logic [MAN_W-1:0] w_fa, w_fb;
    logic             w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
    logic [MAN_W:0]   w_ma, w_mb;
    logic [W-1:0]     w_inf_res, w_zero_res;

    assign w_sa     = r_a[W-1];
    assign w_sb     = r_b[W-1];
    assign w_ea     = r_a[W-2:MAN_W];
    assign w_eb     = r_b[W-2:MAN_W];
    assign w_fa     = r_a[MAN_W-1:0];
    assign w_fb     = r_b[MAN_W-1:0];
    assign w_sign   = w_sa ^ w_sb;
    assign w_a_zero = (w_ea == '0);
    assign w_b_zero = (w_eb == '0);
    assign w_a_inf  = (w_ea == C_EXP_ONES) && (w_fa == '0);
    assign w_b_inf  = (w_eb == C_EXP_ONES) && (w_fb == '0);
    assign w_a_nan  = (w_ea == C_EXP_ONES) && (w_fa != '0);
    assign w_b_nan  = (w_eb == C_EXP_ONES) && (w_fb != '0);
    assign w_ma     = w_a_zero ? '0 : {1'b1, w_fa};
    assign w_mb     = w_b_zero ? '0 : {1'b1, w_fb};
    assign w_inf_res  = {w_sign, C_EXP_ONES, {MAN_W{1'b0}}};
    assign w_zero_res = {w_sign, {(W-1){1'b0}}};

    // One restoring-division step
    logic             w_ge;
    logic [REM_W-1:0] w_rem_sel;
    assign w_ge      = (r_rem >= {{(REM_W-MAN_W-1){1'b0}}, w_mb});
    assign w_rem_sel = w_ge ? (r_rem - {{(REM_W-MAN_W-1){1'b0}}, w_mb}) : r_rem;

    // Normalisation and range check of the finished quotient
    logic signed [EW2-1:0] w_e, w_exp_n;
    logic [MAN_W-1:0]      w_man;
    logic [W-1:0]          w_norm_c;
    logic                  w_norm_ovf, w_norm_unf;

    always_comb begin
        w_e        = $signed({2'b00, w_ea}) - $signed({2'b00, w_eb}) + C_BIAS;
        w_exp_n    = w_e;
        w_man      = r_q[QBITS-2:QBITS-1-MAN_W];
        w_norm_ovf = 1'b0;
        w_norm_unf = 1'b0;
        if (!r_q[QBITS-1]) begin
            w_man   = r_q[QBITS-3:QBITS-2-MAN_W];
            w_exp_n = w_e - C_ONE;
        end
        w_norm_c = {w_sign, w_exp_n[EXP_W-1:0], w_man};
        if (w_exp_n >= C_EMAX) begin
            w_norm_c   = w_inf_res;
            w_norm_ovf = 1'b1;
        end else if (w_exp_n <= C_ZERO) begin
            w_norm_c   = w_zero_res;
            w_norm_unf = 1'b1;
        end
    end

    always_comb begin
        w_state_d   = r_state;
        w_a_d       = r_a;
        w_b_d       = r_b;
        w_rem_d     = r_rem;
        w_q_d       = r_q;
        w_cnt_d     = r_cnt;
        w_spec_d    = r_spec;
        w_spec_c_d  = r_spec_c;
        w_spec_nv_d = r_spec_nv;
        w_spec_dz_d = r_spec_dz;
        w_c_d       = r_c;
        w_nv_d      = r_nv;
        w_dz_d      = r_dz;
        w_ovf_d     = r_ovf;
        w_unf_d     = r_unf;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_a_d     = a;
                    w_b_d     = b;
                    w_state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                w_spec_d    = 1'b1;
                w_spec_nv_d = 1'b0;
                w_spec_dz_d = 1'b0;
                w_spec_c_d  = '0;
                w_state_d   = S_NORM;
                if (w_a_nan || w_b_nan || (w_a_inf && w_b_inf) || (w_a_zero && w_b_zero)) begin
                    w_spec_c_d  = C_QNAN;
                    w_spec_nv_d = 1'b1;
                end else if (w_a_inf) begin
                    w_spec_c_d = w_inf_res;
                end else if (w_b_zero) begin
                    w_spec_c_d  = w_inf_res;
                    w_spec_dz_d = 1'b1;
                end else if (w_a_zero || w_b_inf) begin
                    w_spec_c_d = w_zero_res;
                end else begin
                    w_spec_d  = 1'b0;
                    w_rem_d   = {{(REM_W-MAN_W-1){1'b0}}, w_ma};
                    w_q_d     = '0;
                    w_cnt_d   = CNT_W'(QBITS - 1);
                    w_state_d = S_DIVIDE;
                end
            end
            S_DIVIDE: begin
                w_q_d   = {r_q[QBITS-2:0], w_ge};
                w_rem_d = {w_rem_sel[REM_W-2:0], 1'b0};
                w_cnt_d = r_cnt - 1'b1;
                if (r_cnt == '0) begin
                    w_state_d = S_NORM;
                end
            end
            S_NORM: begin
                // Specials also pass through here so c and flags change only with done
                if (r_spec) begin
                    w_c_d   = r_spec_c;
                    w_nv_d  = r_spec_nv;
                    w_dz_d  = r_spec_dz;
                    w_ovf_d = 1'b0;
                    w_unf_d = 1'b0;
                end else begin
                    w_c_d   = w_norm_c;
                    w_nv_d  = 1'b0;
                    w_dz_d  = 1'b0;
                    w_ovf_d = w_norm_ovf;
                    w_unf_d = w_norm_unf;
                end
                w_state_d = S_DONE;
            end
            S_DONE: begin
                w_state_d = S_IDLE;
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_rem     <= '0;
            r_q       <= '0;
            r_cnt     <= '0;
            r_spec    <= 1'b0;
            r_spec_c  <= '0;
            r_spec_nv <= 1'b0;
            r_spec_dz <= 1'b0;
            r_c       <= '0;
            r_nv      <= 1'b0;
            r_dz      <= 1'b0;
            r_ovf     <= 1'b0;
            r_unf     <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_a       <= w_a_d;
            r_b       <= w_b_d;
            r_rem     <= w_rem_d;
            r_q       <= w_q_d;
            r_cnt     <= w_cnt_d;
            r_spec    <= w_spec_d;
            r_spec_c  <= w_spec_c_d;
            r_spec_nv <= w_spec_nv_d;
            r_spec_dz <= w_spec_dz_d;
            r_c       <= w_c_d;
            r_nv      <= w_nv_d;
            r_dz      <= w_dz_d;
            r_ovf     <= w_ovf_d;
            r_unf     <= w_unf_d;
        end
    end

    assign busy = (r_state != S_IDLE);
    assign done = (r_state == S_DONE);
    assign c    = r_c;
    assign nv   = r_nv;
    assign dz   = r_dz;
    assign ovf  = r_ovf;
    assign unf  = r_unf;

endmodule
`default_nettype wire

// File: tb/tb_fp_div_iter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_div_iter
// Description : Self-checking bench for fp_div_iter: directed vectors, an
//               arithmetic reference model and a per-cycle output checker.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_div_iter;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] a, b;
    logic        busy, done, nv, dz, ovf, unf;
    logic [31:0] c;

    fp_div_iter dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .c(c),
        .nv(nv), .dz(dz), .ovf(ovf), .unf(unf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] c;
        logic [3:0]  f;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    bit   chk_en = 0;
    bit   in_rst = 0;
    logic exp_busy, exp_done;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, act, expv);
        end
    endtask

    // Reference: flags returned as {nv, dz, ovf, unf}; lat = edges from accept to done
    function automatic void model(input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] r, output logic [3:0] f, output int lat);
        logic   s, nanx, nany, infx, infy, zx, zy;
        int     ex, ey, e;
        longint ma, mb, sig;
        s    = x[31] ^ y[31];
        ex   = int'(x[30:23]);
        ey   = int'(y[30:23]);
        nanx = (ex == 255) && (x[22:0] != 0);
        nany = (ey == 255) && (y[22:0] != 0);
        infx = (ex == 255) && (x[22:0] == 0);
        infy = (ey == 255) && (y[22:0] == 0);
        zx   = (ex == 0);
        zy   = (ey == 0);
        f    = 4'b0000;
        lat  = 2;
        r    = 32'h0;
        if (nanx || nany || (infx && infy) || (zx && zy)) begin
            r = 32'h7FC00000;
            f = 4'b1000;
        end else if (infx) begin
            r = {s, 8'hFF, 23'h0};
        end else if (zy) begin
            r = {s, 8'hFF, 23'h0};
            f = 4'b0100;
        end else if (zx || infy) begin
            r = {s, 31'h0};
        end else begin
            lat = 27;
            ma  = longint'({1'b1, x[22:0]});
            mb  = longint'({1'b1, y[22:0]});
            e   = ex - ey + 127;
            // Truncated 24-bit significand of the normalised quotient
            if (ma >= mb) begin
                sig = (ma << 23) / mb;
            end else begin
                sig = (ma << 24) / mb;
                e   = e - 1;
            end
            if (e >= 255) begin
                r = {s, 8'hFF, 23'h0};
                f = 4'b0010;
            end else if (e <= 0) begin
                r = {s, 31'h0};
                f = 4'b0001;
            end else begin
                r = {s, e[7:0], sig[22:0]};
            end
        end
    endfunction

    always @(negedge clk) begin
        if (chk_en && !in_rst) begin
            exp_busy = 1'b0;
            exp_done = 1'b0;
            if (sb.size() > 0) begin
                exp_busy = (cyc >= sb[0].acc);
                exp_done = (cyc == sb[0].acc + sb[0].lat);
            end
            check("busy", {31'b0, busy}, {31'b0, exp_busy});
            check("done", {31'b0, done}, {31'b0, exp_done});
            if (exp_done) begin
                check("c", c, sb[0].c);
                check("flags", {28'b0, nv, dz, ovf, unf}, {28'b0, sb[0].f});
                void'(sb.pop_front());
            end
        end
    end

    // Called at a negedge with the DUT idle; returns at the negedge of the IDLE cycle after done
    task automatic do_op(input logic [31:0] ta, input logic [31:0] tb_v,
                         input logic [31:0] lit_c, input logic [3:0] lit_f,
                         input int lit_lat, input int poke);
        logic [31:0] mc;
        logic [3:0]  mf;
        int          ml;
        exp_t        e;
        model(ta, tb_v, mc, mf, ml);
        check("model_c", mc, lit_c);
        check("model_flags", {28'b0, mf}, {28'b0, lit_f});
        check("model_lat", ml, lit_lat);
        a     = ta;
        b     = tb_v;
        start = 1'b1;
        @(posedge clk);
        #1;
        e.c = mc; e.f = mf; e.lat = ml; e.acc = cyc;
        sb.push_back(e);
        @(negedge clk);
        a = $urandom;
        b = $urandom;
        for (int i = 1; i <= ml + 1; i++) begin
            if (i == poke) begin
                start = 1'b1;
                a     = 32'h7F800000;
                b     = 32'h3F800000;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = 32'h0;
        b     = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'b0, busy}, 32'h0);
        check("rst_done", {31'b0, done}, 32'h0);
        check("rst_c", c, 32'h0);
        check("rst_flags", {28'b0, nv, dz, ovf, unf}, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk_en = 1'b1;

        do_op(32'h41000000, 32'h40000000, 32'h40800000, 4'b0000, 27, 0);
        do_op(32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 4'b0000, 27, 0);
        do_op(32'hC0400000, 32'h40000000, 32'hBFC00000, 4'b0000, 27, 0);
        do_op(32'h40000000, 32'h3F800000, 32'h40000000, 4'b0000, 27, 0);
        do_op(32'h3F800000, 32'h00000000, 32'h7F800000, 4'b0100, 2, 0);
        do_op(32'h7FC00000, 32'h3F800000, 32'h7FC00000, 4'b1000, 2, 0);
        do_op(32'h00000000, 32'h00000000, 32'h7FC00000, 4'b1000, 2, 0);
        do_op(32'h7F800000, 32'h7F800000, 32'h7FC00000, 4'b1000, 2, 0);
        do_op(32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000, 2, 0);
        do_op(32'h00000000, 32'hC0000000, 32'h80000000, 4'b0000, 2, 0);
        do_op(32'h40000000, 32'h7F800000, 32'h00000000, 4'b0000, 2, 0);
        do_op(32'h00400000, 32'h3F800000, 32'h00000000, 4'b0000, 2, 0);
        do_op(32'h3F800000, 32'h00400000, 32'h7F800000, 4'b0100, 2, 0);
        do_op(32'h7F000000, 32'h3E800000, 32'h7F800000, 4'b0010, 27, 0);
        do_op(32'h00800000, 32'h40000000, 32'h00000000, 4'b0001, 27, 0);
        do_op(32'h7F7FFFFF, 32'h3F800000, 32'h7F7FFFFF, 4'b0000, 27, 0);
        do_op(32'h00800000, 32'h3F800000, 32'h00800000, 4'b0000, 27, 0);
        // start pokes while busy: mid-divide, during NORM of a special, in DONE
        do_op(32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 4'b0000, 27, 5);
        do_op(32'h3F800000, 32'h00000000, 32'h7F800000, 4'b0100, 2, 2);
        do_op(32'hC0400000, 32'h40000000, 32'hBFC00000, 4'b0000, 27, 28);
        repeat (5) @(negedge clk);

        a     = 32'h41000000;
        b     = 32'h40000000;
        start = 1'b1;
        @(posedge clk);
        #1;
        sb.push_back('{c: 32'h40800000, f: 4'b0000, lat: 27, acc: cyc});
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        #2;
        in_rst = 1'b1;
        rst    = 1'b1;
        #1;
        check("abort_busy", {31'b0, busy}, 32'h0);
        check("abort_done", {31'b0, done}, 32'h0);
        check("abort_c", c, 32'h0);
        sb.delete();
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        in_rst = 1'b0;
        repeat (40) @(negedge clk);

        do_op(32'h40000000, 32'h3F800000, 32'h40000000, 4'b0000, 27, 0);
        repeat (5) @(negedge clk);
        check("pending", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
